// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, manager state codes and burst helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd1;
    endcase
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    is_wrap = (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for INCR and WRAP bursts; wrapping keeps the bits above
// the burst-sized window and lets only the low bits roll over.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] mask;

  always_comb begin
    incr = ONE << size;
    sum  = addr + incr;
    mask = (incr * ADDR_WIDTH'(burst_beats(burst))) - ONE;
    if (is_wrap(burst)) next_addr = (addr & ~mask) | (sum & mask);
    else                next_addr = sum;
  end

endmodule

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: turns one command at a time into a SINGLE or fixed-length
// INCR/WRAP burst, pipelining address and data phases within the burst.
//
// state | meaning
// IDLE  | cmd_ready high, bus idle
// XFER  | address phase of beat k, data phase of beat k-1
// LAST  | final data phase, HTRANS idle
// ERR2  | second cycle of an ERROR response
module ahb_lite_manager
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [2:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_pop,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  logic [1:0]            state;
  logic [4:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  addr_acc;
  logic                  dp_ok;
  logic                  dp_err;
  logic                  last_beat;
  logic                  cmd_bad;

  ahb_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (HADDR),
    .size      (HSIZE),
    .burst     (HBURST),
    .next_addr (next_addr)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign addr_acc  = (state == ST_XFER) && HREADY;
  assign wr_pop    = addr_acc && HWRITE;
  assign dp_ok     = HREADY && (HRESP == HRESP_OKAY);
  assign dp_err    = !HREADY && (HRESP == HRESP_ERROR);
  assign last_beat = (beat_cnt + 5'd1) == burst_beats(HBURST);
  assign cmd_bad   = (cmd_burst == HBURST_INCR) || (cmd_size > MAX_SIZE);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      beat_cnt <= 5'd0;
      HTRANS   <= HTRANS_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'd0;
      HBURST   <= 3'd0;
      HWDATA   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state    <= ST_XFER;
              beat_cnt <= 5'd0;
              HTRANS   <= HTRANS_NONSEQ;
              HADDR    <= cmd_addr;
              HWRITE   <= cmd_write;
              HSIZE    <= cmd_size;
              HBURST   <= cmd_burst;
            end
          end
        end
        ST_XFER: begin
          // beat_cnt == 0 means no earlier beat is in its data phase yet
          if (dp_err && beat_cnt != 5'd0) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_ERR2;
          end else if (HREADY) begin
            if (beat_cnt != 5'd0 && HRESP == HRESP_OKAY && !HWRITE) begin
              rd_valid <= 1'b1;
              rd_data  <= HRDATA;
            end
            beat_cnt <= beat_cnt + 5'd1;
            if (HWRITE) HWDATA <= wr_data;
            if (last_beat) begin
              HTRANS <= HTRANS_IDLE;
              state  <= ST_LAST;
            end else begin
              HTRANS <= HTRANS_SEQ;
              HADDR  <= next_addr;
            end
          end
        end
        ST_LAST: begin
          if (dp_err) begin
            state <= ST_ERR2;
          end else if (dp_ok) begin
            if (!HWRITE) begin
              rd_valid <= 1'b1;
              rd_data  <= HRDATA;
            end
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          if (HREADY) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
